sev_seg_bank: RTL and testbench

//  Multi-digit decimal display driver for the board's bank of seven-segment displays.
//  - Accepts an unsigned binary value (score, combo count, timer) on a start/busy/done handshake.
//  - Converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine.
//  - Drives NUM_DIGITS registered 8-bit segment patterns, with leading-zero blanking,
//    per-digit decimal points and overflow indication.
//  - Sits between game/score logic and the HEX display pins.

---
 rtl/sev_seg_pkg.sv | 41 ++++
 rtl/seg_glyph.sv | 17 +
 rtl/sev_seg_bank.sv | 127 ++++++++++++
 tb/tb_sev_seg_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared types, glyph constants and helpers for the seven-segment bank
package sev_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } seg_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low patterns, dp off; non-decimal nibbles render blank.
    function automatic logic [7:0] digit_glyph(input logic [3:0] nibble);
        logic [7:0] pat;
        case (nibble)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_glyph.sv
// rtl/seg_glyph.sv - one digit: BCD nibble, dp and leading-zero blank to an active-low pattern
module seg_glyph
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       lz_blank,
    output logic [7:0] pattern
);

    logic [7:0] base;

    assign base    = lz_blank ? SEG_BLANK : digit_glyph(nibble);
    // A blanked leading digit still carries its decimal point.
    assign pattern = {base[7] & ~dp, base[6:0]};

endmodule

// File: rtl/sev_seg_bank.sv
// rtl/sev_seg_bank.sv - double-dabble binary-to-BCD converter driving a bank of seven-segment digits
module sev_seg_bank
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [8*NUM_DIGITS-1:0] segs
);

    localparam int              BCD_W   = 4 * NUM_DIGITS;
    localparam int              CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;
    localparam logic [7:0]      SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

    seg_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        adj;
    logic [BIN_WIDTH-1:0]    bin;
    logic [NUM_DIGITS-1:0]   dp_cap;
    logic                    ovf_cap;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    seen;
    logic [8*NUM_DIGITS-1:0] glyph_pat;
    logic [8*NUM_DIGITS-1:0] next_segs;
    logic [8*NUM_DIGITS-1:0] segs_reg;
    logic [7:0]              pat;

    always_comb begin
        adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz   = '0;
        seen = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            lz[k] = (BLANK_LZ != 0) && !seen;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg_glyph u_glyph (
            .nibble   (bcd[4*g +: 4]),
            .dp       (dp_cap[g]),
            .lz_blank (lz[g]),
            .pattern  (glyph_pat[8*g +: 8])
        );
    end

    always_comb begin
        next_segs = '0;
        pat       = SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            pat = ovf_cap ? SEG_DASH : glyph_pat[8*k +: 8];
            next_segs[8*k +: 8] = (ACTIVE_LOW != 0) ? pat : ~pat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bcd      <= '0;
            bin      <= '0;
            dp_cap   <= '0;
            ovf_cap  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            segs_reg <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin     <= value;
                        dp_cap  <= dp_mask;
                        ovf_cap <= (64'(value) > MAX_VAL);
                        bcd     <= '0;
                        cnt     <= CNT_W'(BIN_WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {adj, bin} << 1;
                    cnt        <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    segs_reg <= next_segs;
                    overflow <= ovf_cap;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign segs = blank ? {NUM_DIGITS{SEG_OFF}} : segs_reg;

endmodule

// File: tb/tb_sev_seg_bank.sv
// tb/tb_sev_seg_bank.sv - randomized self-checking bench for sev_seg_bank against a decimal model
module tb_sev_seg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] value = '0;
    logic [5:0]  dp_mask = '0;
    logic        blank = 1'b0;

    logic        busy_a, done_a, overflow_a;
    logic [47:0] segs_a;
    logic        busy_b, done_b, overflow_b;
    logic [47:0] segs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sev_seg_bank #(.NUM_DIGITS(6), .BIN_WIDTH(20), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .value(value), .dp_mask(dp_mask), .blank(blank),
        .busy(busy_a), .done(done_a), .overflow(overflow_a), .segs(segs_a)
    );

    // Second instance: no zero blanking, active-high outputs.
    sev_seg_bank #(.NUM_DIGITS(6), .BIN_WIDTH(20), .ACTIVE_LOW(0), .BLANK_LZ(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .value(value), .dp_mask(dp_mask), .blank(blank),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .segs(segs_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph_ref(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic logic [47:0] model_segs(input int unsigned v, input logic [5:0] dp,
                                               input bit lz_en, input bit al);
        int unsigned p;
        logic [7:0]  b;
        logic [47:0] r;
        p = 1;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            if (v > 999999) begin
                b = 8'hBF;
            end else begin
                if (lz_en && k > 0 && v < p) b = 8'hFF;
                else                         b = glyph_ref(int'((v / p) % 10));
                if (dp[k]) b[7] = 1'b0;
            end
            r[8*k +: 8] = al ? b : ~b;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_disp(input string tag, input int unsigned v, input logic [5:0] dp);
        check({tag, "_segs_a"}, 64'(segs_a), 64'(model_segs(v, dp, 1'b1, 1'b1)));
        check({tag, "_segs_b"}, 64'(segs_b), 64'(model_segs(v, dp, 1'b0, 1'b0)));
        check({tag, "_ovf_a"}, 64'(overflow_a), 64'(v > 999999));
        check({tag, "_ovf_b"}, 64'(overflow_b), 64'(v > 999999));
    endtask

    // Waits for done after the accepting edge; returns edges elapsed and busy samples seen.
    task automatic wait_done(input string tag, output int cyc, output int nb);
        bit got;
        got = 0;
        cyc = 0;
        nb  = busy_a ? 1 : 0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                got = 1;
                cyc = i;
                check({tag, "_done_b"}, 64'(done_b), 64'd1);
            end else if (busy_a) begin
                nb++;
            end
        end
        if (!got) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_conv(input string tag, input logic [19:0] v, input logic [5:0] dp,
                            input bit timing);
        int cyc, nb;
        @(negedge clk);
        value   = v;
        dp_mask = dp;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tag, cyc, nb);
        if (timing) begin
            check({tag, "_latency"}, 64'(cyc), 64'd21);
            check({tag, "_busy_cycles"}, 64'(nb), 64'd21);
        end
        check_disp(tag, int'(v), dp);
    endtask

    initial begin
        logic [19:0] v, v2;
        logic [5:0]  dp;
        int          cyc, nb, done_cnt;
        logic [47:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_done", 64'(done_a), 64'd0);
        check("reset_ovf", 64'(overflow_a), 64'd0);
        check("reset_segs_a", 64'(segs_a), 64'hFFFF_FFFF_FFFF);
        check("reset_segs_b", 64'(segs_b), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv("t1_123456", 20'd123456, 6'b0, 1'b1);
        check("t1_literal", 64'(segs_a), 64'hF9A4_B099_9282);
        run_conv("t2_zero", 20'd0, 6'b0, 1'b1);
        check("t2_zero_literal", 64'(segs_a), 64'hFFFF_FFFF_FFC0);
        run_conv("t2_405", 20'd405, 6'b0, 1'b0);
        check("t2_405_literal", 64'(segs_a), 64'hFFFF_FF99_C092);
        run_conv("t3_ovf", 20'd1000000, 6'b111111, 1'b1);
        check("t3_ovf_literal", 64'(segs_a), 64'hBFBF_BFBF_BFBF);
        run_conv("t3_seven", 20'd7, 6'b0, 1'b0);

        // Start held high, value changing while busy.
        v  = 20'd54321;
        v2 = 20'd98765;
        @(negedge clk);
        value   = v;
        dp_mask = 6'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        value = v2;
        wait_done("t4_first", cyc, nb);
        check("t4_first_latency", 64'(cyc), 64'd21);
        check_disp("t4_first", int'(v), 6'b0);
        @(posedge clk);
        #1;
        check("t4_reaccept_busy", 64'(busy_a), 64'd1);
        start = 1'b0;
        wait_done("t4_second", cyc, nb);
        check("t4_second_latency", 64'(cyc), 64'd21);
        check_disp("t4_second", int'(v2), 6'b0);

        run_conv("t5_dp", 20'd12345, 6'b000100, 1'b0);
        check("t5_dp_digit2", 64'(segs_a[23:16]), 64'h30);
        held = segs_a;
        @(negedge clk);
        blank = 1'b1;
        #1;
        check("t5_blank_a", 64'(segs_a), 64'hFFFF_FFFF_FFFF);
        check("t5_blank_b", 64'(segs_b), 64'd0);
        repeat (3) @(negedge clk);
        blank = 1'b0;
        #1;
        check("t5_restore", 64'(segs_a), 64'(held));
        check("t5_no_done", 64'(done_a), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_hold", 64'(segs_a), 64'(held));

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: v = 20'($urandom_range(0, 99));
                1: v = 20'($urandom_range(0, 999999));
                2: v = 20'($urandom_range(1000000, 1048575));
                default: begin
                    case ($urandom_range(0, 4))
                        0: v = 20'd999999;
                        1: v = 20'd100000;
                        2: v = 20'd10;
                        3: v = 20'd9;
                        default: v = 20'd1000000;
                    endcase
                end
            endcase
            dp = 6'($urandom);
            run_conv($sformatf("rnd%0d", i), v, dp, (i % 6) == 0);
        end

        // Reset mid-conversion, from a display that shows overflow.
        run_conv("t6_pre", 20'd1000001, 6'b0, 1'b0);
        @(negedge clk);
        value = 20'd4242;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy_a), 64'd0);
        check("t6_rst_segs_a", 64'(segs_a), 64'hFFFF_FFFF_FFFF);
        check("t6_rst_segs_b", 64'(segs_b), 64'd0);
        check("t6_rst_ovf", 64'(overflow_a), 64'd0);
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a) done_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_a || busy_a) done_cnt++;
        end
        check("t6_no_done", 64'(done_cnt), 64'd0);
        run_conv("t6_fresh", 20'd4242, 6'b000001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
